// File: rtl/b1_scfifo_pkg.sv
// Shared types and constants for the b1_scfifo read-side stream adapter.
package b1_scfifo_pkg;

    typedef logic [1:0] occ_t;

    localparam int BUF_DEPTH = 2;
    localparam int STAT_W    = 32;

endpackage

// File: rtl/b1_skid_buf2.sv
// Two-entry register buffer with head/tail pointers; the head entry drives dout_o.
module b1_skid_buf2
    import b1_scfifo_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DWIDTH-1:0] din_i,
    output logic [DWIDTH-1:0] dout_o,
    output occ_t              occ_o
);

    logic [DWIDTH-1:0] r_mem [BUF_DEPTH];
    logic              r_head;
    logic              r_tail;
    occ_t              r_occ;
    logic              w_push;
    logic              w_pop;

    // A push into a full buffer is only legal when the head leaves in the same clock.
    assign w_pop  = pop_i & (r_occ != '0);
    assign w_push = push_i & ((r_occ != occ_t'(BUF_DEPTH)) | w_pop);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_occ  <= '0;
        end else if (clear_i) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= din_i;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push & ~w_pop) begin
                r_occ <= r_occ + 2'd1;
            end else if (w_pop & ~w_push) begin
                r_occ <= r_occ - 2'd1;
            end
        end
    end

    assign dout_o = r_mem[r_head];
    assign occ_o  = r_occ;

endmodule

// File: rtl/b1_scfifo_rd_stream.sv
// Read adapter for b1_scfifo (normal mode): issues rdreq, absorbs q latency, emits valid/ready stream.
// Define B1_SCFIFO_RD_STAT_EN to add the words_o / stall_o statistics counters.
module b1_scfifo_rd_stream
    import b1_scfifo_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              flush_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i
`ifdef B1_SCFIFO_RD_STAT_EN
    ,
    output logic [STAT_W-1:0] words_o,
    output logic [STAT_W-1:0] stall_o
`endif
);

    // The statistics counters must be wide enough to count a full FIFO's worth of words.
    if (AWIDTH >= STAT_W) begin : g_awidth_too_wide
        $error("b1_scfifo_rd_stream: AWIDTH must be smaller than STAT_W");
    end

    logic       r_infl;
    occ_t       w_occ;
    logic       w_pop;
    logic       w_pop_buf;
    logic       w_push_buf;
    logic [2:0] w_level;

    assign valid_o = (w_occ != '0);
    assign w_pop   = valid_o & ready_i;

    // Words that will be resident after this clock; a new request only fits below 2.
    assign w_level      = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign fifo_rdreq_o = ~arst_i & ~fifo_empty_i & ~flush_i & (w_level < 3'd2);

    assign w_push_buf = r_infl & ~flush_i;
    assign w_pop_buf  = w_pop & ~flush_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_infl <= 1'b0;
        end else begin
            r_infl <= fifo_rdreq_o;
        end
    end

    b1_skid_buf2 #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .clear_i (flush_i),
        .push_i  (w_push_buf),
        .pop_i   (w_pop_buf),
        .din_i   (fifo_q_i),
        .dout_o  (data_o),
        .occ_o   (w_occ)
    );

`ifdef B1_SCFIFO_RD_STAT_EN
    logic [STAT_W-1:0] r_words;
    logic [STAT_W-1:0] r_stall;

    // Flush does not clear the statistics; only reset does.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_words <= '0;
            r_stall <= '0;
        end else begin
            if (w_pop_buf) begin
                r_words <= r_words + STAT_W'(1);
            end
            if (valid_o & ~ready_i) begin
                r_stall <= r_stall + STAT_W'(1);
            end
        end
    end

    assign words_o = r_words;
    assign stall_o = r_stall;
`endif

endmodule

// File: tb/tb_b1_scfifo_rd_stream.sv
// Self-checking bench for b1_scfifo_rd_stream: queue-based reference model plus directed literal checks.
module tb_b1_scfifo_rd_stream;

    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          arst_i;
    logic          flush_i;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_q_i;
    logic          fifo_rdreq_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
`ifdef B1_SCFIFO_RD_STAT_EN
    logic [31:0]   words_o;
    logic [31:0]   stall_o;
`endif

    always #5 clk_i = ~clk_i;

    b1_scfifo_rd_stream #(
        .DWIDTH (DW),
        .AWIDTH (8)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_q_i     (fifo_q_i),
        .fifo_rdreq_o (fifo_rdreq_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
`ifdef B1_SCFIFO_RD_STAT_EN
        ,
        .words_o      (words_o),
        .stall_o      (stall_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Environment FIFO (driven by the DUT's rdreq) and the model's own copy of it.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] m_src[$];
    // Model output buffer: words that must appear on data_o, head first.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] m_infl_w;
    bit            m_infl;
    bit            exp_rd;
    bit            dut_rd_s;
    int            m_words;
    int            m_stall;
    int            n_rd;
    int            n_pop;
    int            cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs checked against the model on every cycle at the falling edge.
    task automatic sample();
        int lvl;
        @(negedge clk_i);
        lvl    = exp_q.size() + int'(m_infl) - int'(exp_q.size() > 0 && ready_i);
        exp_rd = (m_src.size() > 0) && !flush_i && (lvl < 2);
        chk("rdreq", {31'd0, fifo_rdreq_o}, {31'd0, exp_rd});
        chk("valid", {31'd0, valid_o}, {31'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) chk("data", {24'd0, data_o}, {24'd0, exp_q[0]});
`ifdef B1_SCFIFO_RD_STAT_EN
        chk("words_o", words_o, m_words);
        chk("stall_o", stall_o, m_stall);
`endif
        dut_rd_s = fifo_rdreq_o;
        if (fifo_rdreq_o) n_rd++;
        if (valid_o && ready_i && !flush_i) begin
            n_pop++;
            got_q.push_back(data_o);
        end
    endtask

    task automatic advance();
        bit pop;
        @(posedge clk_i);
        cyc++;
        pop = (exp_q.size() > 0) && ready_i && !flush_i;
        if (exp_q.size() > 0 && !ready_i) m_stall++;
        if (pop) m_words++;
        if (flush_i) begin
            exp_q.delete();
            m_infl = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (m_infl) exp_q.push_back(m_infl_w);
            m_infl = exp_rd;
            if (exp_rd) m_infl_w = m_src.pop_front();
        end
        #1;
        if (dut_rd_s && src_q.size() > 0) fifo_q_i = src_q.pop_front();
        else fifo_q_i = DW'($urandom);
        fifo_empty_i = (src_q.size() == 0);
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        src_q.push_back(w);
        m_src.push_back(w);
        fifo_empty_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        ready_i = 1'b1;
        flush_i = 1'b0;
        k = 0;
        while ((m_src.size() > 0 || exp_q.size() > 0 || m_infl) && k < 60) begin
            tick();
            k++;
        end
        if (k >= 60) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int first_cyc;
        int last_cyc;
        int k;
        logic [DW-1:0] held;
        int w0;
        int s0;

        arst_i       = 1'b1;
        flush_i      = 1'b0;
        ready_i      = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_q_i     = '0;
        m_infl       = 1'b0;
        m_words      = 0;
        m_stall      = 0;
        cyc          = 0;
        w0           = 0;
        s0           = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_data", {24'd0, data_o}, 32'd0);
        chk("reset_rdreq", {31'd0, fifo_rdreq_o}, 32'd0);
        arst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Latency: rdreq at N, word visible at N+2.
        ready_i = 1'b1;
        push_word(8'hA5);
        sample();
        chk("lat_rdreq_n", {31'd0, fifo_rdreq_o}, 32'd1);
        advance();
        sample();
        chk("lat_valid_n1", {31'd0, valid_o}, 32'd0);
        advance();
        sample();
        chk("lat_valid_n2", {31'd0, valid_o}, 32'd1);
        chk("lat_data_n2", {24'd0, data_o}, 32'hA5);
        advance();
        drain();

        // Streaming: 16 words with ready held high.
`ifdef B1_SCFIFO_RD_STAT_EN
        w0 = words_o;
`endif
        got_q.delete();
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        first_cyc = -1;
        last_cyc  = -1;
        for (int i = 0; i < 30; i++) begin
            sample();
            if (valid_o) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            advance();
        end
        chk("stream_count", got_q.size(), 32'd16);
        chk("stream_no_gap", last_cyc - first_cyc, 32'd15);
        for (int i = 0; i < 16 && i < got_q.size(); i++) chk("stream_order", {24'd0, got_q[i]}, i);
`ifdef B1_SCFIFO_RD_STAT_EN
        chk("stream_words", words_o - w0, 32'd16);
`endif

        // Backpressure: 5 stalled clocks mid-burst.
        got_q.delete();
        for (int i = 0; i < 8; i++) push_word(DW'(8'h20 + i));
        repeat (4) tick();
`ifdef B1_SCFIFO_RD_STAT_EN
        s0 = stall_o;
`endif
        ready_i = 1'b0;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("bp_rdreq_low", {31'd0, fifo_rdreq_o}, 32'd0);
            if (i == 0) held = data_o;
            else chk("bp_data_held", {24'd0, data_o}, {24'd0, held});
            advance();
        end
`ifdef B1_SCFIFO_RD_STAT_EN
        chk("bp_stall", stall_o - s0, 32'd5);
`endif
        drain();
        chk("bp_count", got_q.size(), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) chk("bp_order", {24'd0, got_q[i]}, 32'h20 + i);

        // Flush with one word buffered and one in flight.
        ready_i = 1'b0;
        for (int i = 0; i < 8; i++) push_word(DW'(8'h50 + i));
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        sample();
        chk("flush_valid_low", {31'd0, valid_o}, 32'd0);
        advance();
        got_q.delete();
        ready_i = 1'b1;
        k = 0;
        while (got_q.size() == 0 && k < 20) begin
            tick();
            k++;
        end
        chk("flush_next_word", got_q.size() > 0 ? {24'd0, got_q[0]} : 32'hFFFF, 32'h52);
        drain();

        // Empty edge: single word, ready toggling.
        n_rd  = 0;
        n_pop = 0;
        push_word(8'h3C);
        for (int i = 0; i < 12; i++) begin
            ready_i = i[0];
            tick();
        end
        chk("edge_rdreq_count", n_rd, 32'd1);
        chk("edge_pop_count", n_pop, 32'd1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) push_word(DW'($urandom));
            end
            ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush_i = 1'b0;

        // Reset mid-stream: outputs drop immediately, counters clear.
        for (int i = 0; i < 10; i++) push_word(DW'(8'h70 + i));
        ready_i = 1'b1;
        repeat (4) tick();
        arst_i = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_mid_rdreq", {31'd0, fifo_rdreq_o}, 32'd0);
        chk("rst_mid_data", {24'd0, data_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        src_q.delete();
        m_src.delete();
        exp_q.delete();
        m_infl       = 1'b0;
        m_words      = 0;
        m_stall      = 0;
        fifo_empty_i = 1'b1;
        @(negedge clk_i);
`ifdef B1_SCFIFO_RD_STAT_EN
        chk("rst_words", words_o, 32'd0);
`endif
        arst_i = 1'b0;
        @(posedge clk_i);
        #1;
        got_q.delete();
        push_word(8'hC3);
        drain();
        chk("post_rst_word", got_q.size() > 0 ? {24'd0, got_q[0]} : 32'hFFFF, 32'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
